// File: rtl/axi_master_arbiter.sv
// Round-robin arbiter sharing one single-beat AXI4 master port between IFU reads and LSU reads/writes.
// Read completes 3 cycles after req with a zero-wait slave; one transaction in flight, requesters hold req until done.
module axi_master_arbiter #(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 64,
  parameter logic [3:0] IFU_ID = 4'd0,
  parameter logic [3:0] LSU_ID = 4'd1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ifu_req,
  input  logic [ADDR_W-1:0]     ifu_addr,
  output logic                  ifu_done,
  output logic [DATA_W-1:0]     ifu_rdata,
  output logic                  ifu_err,
  input  logic                  lsu_req,
  input  logic                  lsu_we,
  input  logic [ADDR_W-1:0]     lsu_addr,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W/8-1:0]   lsu_wstrb,
  output logic                  lsu_done,
  output logic [DATA_W-1:0]     lsu_rdata,
  output logic                  lsu_err,
  output logic                  io_master_arvalid,
  output logic [ADDR_W-1:0]     io_master_araddr,
  output logic [3:0]            io_master_arid,
  output logic [7:0]            io_master_arlen,
  output logic [2:0]            io_master_arsize,
  output logic [1:0]            io_master_arburst,
  input  logic                  io_master_arready,
  input  logic                  io_master_rvalid,
  input  logic [DATA_W-1:0]     io_master_rdata,
  input  logic [1:0]            io_master_rresp,
  input  logic [3:0]            io_master_rid,
  input  logic                  io_master_rlast,
  output logic                  io_master_rready,
  output logic                  io_master_awvalid,
  output logic [ADDR_W-1:0]     io_master_awaddr,
  output logic [3:0]            io_master_awid,
  output logic [7:0]            io_master_awlen,
  output logic [2:0]            io_master_awsize,
  output logic [1:0]            io_master_awburst,
  input  logic                  io_master_awready,
  output logic                  io_master_wvalid,
  output logic [DATA_W-1:0]     io_master_wdata,
  output logic [DATA_W/8-1:0]   io_master_wstrb,
  output logic                  io_master_wlast,
  input  logic                  io_master_wready,
  input  logic                  io_master_bvalid,
  input  logic [1:0]            io_master_bresp,
  input  logic [3:0]            io_master_bid,
  output logic                  io_master_bready
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, DONE} state_t;

  typedef struct packed {
    logic [3:0]        id;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_t;

  state_t state_q, state_d;
  req_t   req_q, req_d;
  logic   last_lsu_q, last_lsu_d;  // also identifies the owner of the transaction in flight
  logic   aw_ok_q, aw_ok_d;
  logic   w_ok_q, w_ok_d;
  rsp_t   ifu_rsp_q, ifu_rsp_d;
  rsp_t   lsu_rsp_q, lsu_rsp_d;
  logic   rd_err, wr_err;
  logic   unused_rlast;

  assign rd_err       = (io_master_rresp != 2'b00) || (io_master_rid != req_q.id);
  assign wr_err       = (io_master_bresp != 2'b00) || (io_master_bid != LSU_ID);
  assign unused_rlast = io_master_rlast;

  always_comb begin
    state_d           = state_q;
    req_d             = req_q;
    last_lsu_d        = last_lsu_q;
    aw_ok_d           = aw_ok_q;
    w_ok_d            = w_ok_q;
    ifu_rsp_d         = ifu_rsp_q;
    lsu_rsp_d         = lsu_rsp_q;
    io_master_arvalid = 1'b0;
    io_master_rready  = 1'b0;
    io_master_awvalid = 1'b0;
    io_master_wvalid  = 1'b0;
    io_master_bready  = 1'b0;
    ifu_done          = 1'b0;
    lsu_done          = 1'b0;

    unique case (state_q)
      IDLE: begin
        aw_ok_d = 1'b0;
        w_ok_d  = 1'b0;
        // On contention the requester that did not win last time goes first.
        if (lsu_req && (!ifu_req || !last_lsu_q)) begin
          last_lsu_d = 1'b1;
          req_d      = '{id: LSU_ID, we: lsu_we, addr: lsu_addr, wdata: lsu_wdata, wstrb: lsu_wstrb};
          state_d    = lsu_we ? WR_ADDR : RD_ADDR;
        end else if (ifu_req) begin
          last_lsu_d = 1'b0;
          req_d      = '{id: IFU_ID, we: 1'b0, addr: ifu_addr, wdata: '0, wstrb: '0};
          state_d    = RD_ADDR;
        end
      end
      RD_ADDR: begin
        io_master_arvalid = 1'b1;
        if (io_master_arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        io_master_rready = 1'b1;
        if (io_master_rvalid) begin
          if (last_lsu_q) lsu_rsp_d = '{rdata: io_master_rdata, err: rd_err};
          else            ifu_rsp_d = '{rdata: io_master_rdata, err: rd_err};
          state_d = DONE;
        end
      end
      WR_ADDR: begin
        // AW and W complete independently; a same-cycle double handshake is fine.
        io_master_awvalid = !aw_ok_q;
        io_master_wvalid  = !w_ok_q;
        aw_ok_d = aw_ok_q | io_master_awready;
        w_ok_d  = w_ok_q | io_master_wready;
        if (aw_ok_d && w_ok_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        io_master_bready = 1'b1;
        if (io_master_bvalid) begin
          lsu_rsp_d.err = wr_err;
          state_d       = DONE;
        end
      end
      DONE: begin
        ifu_done = !last_lsu_q;
        lsu_done = last_lsu_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      req_q      <= '0;
      last_lsu_q <= 1'b1;
      aw_ok_q    <= 1'b0;
      w_ok_q     <= 1'b0;
      ifu_rsp_q  <= '0;
      lsu_rsp_q  <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      last_lsu_q <= last_lsu_d;
      aw_ok_q    <= aw_ok_d;
      w_ok_q     <= w_ok_d;
      ifu_rsp_q  <= ifu_rsp_d;
      lsu_rsp_q  <= lsu_rsp_d;
    end
  end

  assign ifu_rdata         = ifu_rsp_q.rdata;
  assign ifu_err           = ifu_rsp_q.err;
  assign lsu_rdata         = lsu_rsp_q.rdata;
  assign lsu_err           = lsu_rsp_q.err;

  assign io_master_araddr  = req_q.addr;
  assign io_master_arid    = req_q.id;
  assign io_master_arlen   = 8'd0;
  assign io_master_arsize  = 3'b011;
  assign io_master_arburst = 2'b01;
  assign io_master_awaddr  = req_q.addr;
  assign io_master_awid    = req_q.id;
  assign io_master_awlen   = 8'd0;
  assign io_master_awsize  = 3'b011;
  assign io_master_awburst = 2'b01;
  assign io_master_wdata   = req_q.wdata;
  assign io_master_wstrb   = req_q.wstrb;
  assign io_master_wlast   = 1'b1;

endmodule
